// File: rtl/fetch_unit.sv
// Instruction fetch front end: single-outstanding memory requests feeding a
// DEPTH-entry prefetch queue, with redirect flush and sticky halt.
module fetch_unit #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 16,
   parameter int DEPTH    = 4,
   parameter int INC      = 2,
   parameter int RESET_PC = 0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_rdy,
   input  logic              imem_rvalid,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   input  logic              instr_ready,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              hlt,
   output logic              halted,
   output logic [ADDR_W-1:0] pc_out
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_req_pc;
   logic [ADDR_W-1:0] r_q_pc  [DEPTH];
   logic [DATA_W-1:0] r_q_ins [DEPTH];
   logic [PTR_W-1:0]  r_head;
   logic [PTR_W-1:0]  r_tail;
   logic [CNT_W-1:0]  r_count;
   logic              r_out;
   logic              r_drop;
   logic              r_halted;

   logic w_accept;
   logic w_resp;
   logic w_push;
   logic w_pop;

   // Issuing only with no request in flight and a free slot means every
   // response always has room in the queue.
   assign imem_req = !rst && !r_halted && !redirect_valid && !r_out &&
                     (r_count < CNT_W'(DEPTH));
   assign w_accept = imem_req && imem_rdy;
   assign w_resp   = imem_rvalid && r_out;
   assign w_push   = w_resp && !r_drop && !redirect_valid;
   assign w_pop    = instr_valid && instr_ready && !redirect_valid;

   assign imem_addr   = r_pc;
   assign pc_out      = r_pc;
   assign halted      = r_halted;
   assign instr_valid = (r_count != '0);
   assign instr       = r_q_ins[r_head];
   assign instr_pc    = r_q_pc[r_head];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_q_pc[i]  <= '0;
            r_q_ins[i] <= '0;
         end
      end else if (w_push) begin
         r_q_pc[r_tail]  <= r_req_pc;
         r_q_ins[r_tail] <= imem_rdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc     <= ADDR_W'(RESET_PC);
         r_req_pc <= '0;
         r_head   <= '0;
         r_tail   <= '0;
         r_count  <= '0;
         r_out    <= 1'b0;
         r_drop   <= 1'b0;
         r_halted <= 1'b0;
      end else begin
         if (hlt)
            r_halted <= 1'b1;
         if (redirect_valid) begin
            // A request still in flight is remembered so its data is thrown away.
            r_pc    <= redirect_pc;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_out   <= r_out && !imem_rvalid;
            r_drop  <= r_out && !imem_rvalid;
         end else begin
            if (w_resp) begin
               r_out  <= 1'b0;
               r_drop <= 1'b0;
            end
            if (w_accept) begin
               r_out    <= 1'b1;
               r_req_pc <= r_pc;
               r_pc     <= r_pc + ADDR_W'(INC);
            end
            if (w_push)
               r_tail <= r_tail + PTR_W'(1);
            if (w_pop)
               r_head <= r_head + PTR_W'(1);
            if (w_push && !w_pop)
               r_count <= r_count + CNT_W'(1);
            else if (!w_push && w_pop)
               r_count <= r_count - CNT_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit: a latency-randomised memory plus a
// queue-based reference model of the fetch stream checked every cycle.
module tb_fetch_unit;
   localparam int DEPTH = 4;
   localparam int INC   = 2;
   localparam logic [15:0] RST_PC = 16'h0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req, imem_rdy, imem_rvalid;
   logic [15:0] imem_addr, imem_rdata;
   logic        instr_valid, instr_ready;
   logic [15:0] instr, instr_pc;
   logic        redirect_valid, hlt, halted;
   logic [15:0] redirect_pc, pc_out;

   fetch_unit #(.ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH), .INC(INC), .RESET_PC(0)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdy(imem_rdy),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .hlt(hlt), .halted(halted), .pc_out(pc_out)
   );

   always #5 clk = ~clk;

   int ntot = 0;
   int npass = 0;

   // reference model
   logic [15:0] m_fpc, m_rpc;
   bit          m_out, m_drop, m_halted;
   logic [15:0] m_q[$];

   // memory model
   typedef struct { logic [15:0] a; int due; } mreq_t;
   mreq_t mq[$];
   int cyc = 0;
   int lat_lo = 1;
   int lat_hi = 1;

   function automatic logic [15:0] memf(logic [15:0] a);
      return (a * 16'h9E37) ^ 16'h5A3C;
   endfunction

   function automatic bit exp_req();
      return !rst && !m_halted && !redirect_valid && !m_out && (m_q.size() < DEPTH);
   endfunction

   function automatic logic [34:0] exp_ctl();
      return {exp_req(), m_fpc, m_fpc, (m_q.size() != 0), m_halted};
   endfunction

   function automatic logic [31:0] exp_head();
      return {m_q[0], memf(m_q[0])};
   endfunction

   task automatic model_reset();
      m_fpc = RST_PC; m_rpc = '0; m_out = 0; m_drop = 0; m_halted = 0;
      m_q.delete();
   endtask

   task automatic drive(input bit rdy, input bit rdyc, input bit redir,
                        input logic [15:0] rpc, input bit h);
      imem_rdy = rdy; instr_ready = rdyc; redirect_valid = redir;
      redirect_pc = rpc; hlt = h;
      if (mq.size() != 0 && mq[0].due <= cyc) begin
         imem_rvalid = 1'b1; imem_rdata = memf(mq[0].a);
      end else begin
         imem_rvalid = 1'b0; imem_rdata = 16'($urandom);
      end
      #1;
   endtask

   task automatic advance();
      bit acc, pop;
      if (imem_req === 1'b1 && imem_rdy)
         mq.push_back('{a: imem_addr, due: cyc + int'($urandom_range(lat_hi, lat_lo))});
      if (imem_rvalid) void'(mq.pop_front());
      if (!rst) begin
         acc = exp_req() && imem_rdy;
         pop = (m_q.size() != 0) && instr_ready && !redirect_valid;
         if (redirect_valid) begin
            m_q.delete();
            m_fpc  = redirect_pc;
            m_drop = m_out && !imem_rvalid;
            m_out  = m_drop;
         end else begin
            if (pop) void'(m_q.pop_front());
            if (imem_rvalid && m_out) begin
               if (!m_drop) m_q.push_back(m_rpc);
               m_out = 0; m_drop = 0;
            end
            if (acc) begin
               m_out = 1; m_rpc = m_fpc; m_fpc = m_fpc + 16'(INC);
            end
         end
         if (hlt) m_halted = 1;
      end
      @(posedge clk); @(negedge clk); cyc++;
   endtask

   task automatic reset_dut(input int n);
      rst = 1'b1;
      model_reset();
      repeat (n) begin drive(0, 0, 0, '0, 0); advance(); end
      rst = 1'b0;
   endtask

   task automatic test_reset();
      lat_lo = 1; lat_hi = 1;
      rst = 1'b1;
      drive(0, 0, 0, '0, 0);
      model_reset();
      ntot++;
      if ({imem_req, instr_valid, halted, pc_out} !== {3'b000, RST_PC})
         $display("FAIL reset_state: got %h want %h", {imem_req, instr_valid, halted, pc_out}, {3'b000, RST_PC});
      else npass++;
      advance();
      drive(0, 0, 0, '0, 0); advance();
      rst = 1'b0;
      drive(1, 0, 0, '0, 0);
      ntot++;
      if ({imem_req, imem_addr} !== {1'b1, RST_PC})
         $display("FAIL first_req: got %h want %h", {imem_req, imem_addr}, {1'b1, RST_PC});
      else npass++;
      advance();
   endtask

   task automatic test_stream();
      logic [15:0] seen[$];
      int seen_c[$];
      for (int i = 0; i < 12; i++) begin
         drive(1, 1, 0, '0, 0);
         ntot++;
         if ({imem_req, imem_addr, pc_out, instr_valid, halted} !== exp_ctl())
            $display("FAIL stream_ctl: got %h want %h", {imem_req, imem_addr, pc_out, instr_valid, halted}, exp_ctl());
         else npass++;
         if (m_q.size() != 0) begin
            ntot++;
            if ({instr_pc, instr} !== exp_head())
               $display("FAIL stream_head: got %h want %h", {instr_pc, instr}, exp_head());
            else npass++;
         end
         if (instr_valid === 1'b1) begin seen.push_back(instr_pc); seen_c.push_back(cyc); end
         advance();
      end
      ntot++;
      if (seen.size() < 3 || seen[0] !== 16'h0000 || seen[1] !== 16'h0002 || seen[2] !== 16'h0004)
         $display("FAIL stream_seq: got %0d pops first %h want 0000,0002,0004",
                  seen.size(), (seen.size() != 0) ? seen[0] : 16'hxxxx);
      else npass++;
      ntot++;
      if (seen_c.size() < 3 || seen_c[1] - seen_c[0] != 2 || seen_c[2] - seen_c[1] != 2)
         $display("FAIL stream_rate: got %0d pops, want one every 2 cycles", seen_c.size());
      else npass++;
   endtask

   task automatic test_backpressure();
      int nacc = 0;
      reset_dut(1);
      lat_lo = 1; lat_hi = 2;
      for (int i = 0; i < 16; i++) begin
         drive(1, 0, 0, '0, 0);
         ntot++;
         if ({imem_req, imem_addr, pc_out, instr_valid, halted} !== exp_ctl())
            $display("FAIL bp_ctl: got %h want %h", {imem_req, imem_addr, pc_out, instr_valid, halted}, exp_ctl());
         else npass++;
         if (imem_req === 1'b1 && imem_rdy) nacc++;
         advance();
      end
      ntot++;
      if (nacc != DEPTH) $display("FAIL bp_fill: got %0d requests want %0d", nacc, DEPTH);
      else npass++;
      drive(1, 1, 0, '0, 0);
      ntot++;
      if ({imem_req, instr_valid, instr_pc} !== {2'b01, 16'h0000})
         $display("FAIL bp_full: got %h want %h", {imem_req, instr_valid, instr_pc}, {2'b01, 16'h0000});
      else npass++;
      advance();
      nacc = 0;
      for (int i = 0; i < 6; i++) begin
         drive(1, 0, 0, '0, 0);
         ntot++;
         if ({imem_req, imem_addr, pc_out, instr_valid, halted} !== exp_ctl())
            $display("FAIL bp_ctl2: got %h want %h", {imem_req, imem_addr, pc_out, instr_valid, halted}, exp_ctl());
         else npass++;
         if (imem_req === 1'b1 && imem_rdy) nacc++;
         advance();
      end
      ntot++;
      if (nacc != 1) $display("FAIL bp_refill: got %0d requests want 1", nacc);
      else npass++;
   endtask

   task automatic test_redirect();
      bit found = 0;
      bit popped = 0;
      reset_dut(1);
      lat_lo = 3; lat_hi = 3;
      for (int i = 0; i < 40 && !found; i++) begin
         drive(1, 0, 0, '0, 0);
         ntot++;
         if ({imem_req, imem_addr, pc_out, instr_valid, halted} !== exp_ctl())
            $display("FAIL redir_ctl: got %h want %h", {imem_req, imem_addr, pc_out, instr_valid, halted}, exp_ctl());
         else npass++;
         advance();
         found = m_out && (m_rpc == 16'h0006);
      end
      ntot++;
      if (!found) $display("FAIL redir_setup: got no outstanding 0006 want one");
      else npass++;
      drive(1, 1, 1, 16'h0040, 0);
      advance();
      for (int i = 0; i < 30 && !popped; i++) begin
         drive(1, 1, 0, '0, 0);
         ntot++;
         if ({imem_req, imem_addr, pc_out, instr_valid, halted} !== exp_ctl())
            $display("FAIL redir_ctl2: got %h want %h", {imem_req, imem_addr, pc_out, instr_valid, halted}, exp_ctl());
         else npass++;
         if (instr_valid === 1'b1) begin
            popped = 1;
            ntot++;
            if ({instr_pc, instr} !== {16'h0040, memf(16'h0040)})
               $display("FAIL redir_target: got %h want %h", {instr_pc, instr}, {16'h0040, memf(16'h0040)});
            else npass++;
         end
         advance();
      end
      ntot++;
      if (!popped) $display("FAIL redir_timeout: got no instr want pc 0040");
      else npass++;
   endtask

   task automatic test_wrap();
      logic [15:0] seen[$];
      reset_dut(1);
      lat_lo = 1; lat_hi = 1;
      drive(1, 1, 1, 16'hFFFE, 0); advance();
      for (int i = 0; i < 10; i++) begin
         drive(1, 1, 0, '0, 0);
         ntot++;
         if ({imem_req, imem_addr, pc_out, instr_valid, halted} !== exp_ctl())
            $display("FAIL wrap_ctl: got %h want %h", {imem_req, imem_addr, pc_out, instr_valid, halted}, exp_ctl());
         else npass++;
         if (instr_valid === 1'b1) seen.push_back(instr_pc);
         advance();
      end
      ntot++;
      if (seen.size() < 2 || seen[0] !== 16'hFFFE || seen[1] !== 16'h0000)
         $display("FAIL wrap_seq: got %0d pops first %h want FFFE,0000",
                  seen.size(), (seen.size() != 0) ? seen[0] : 16'hxxxx);
      else npass++;
   endtask

   task automatic test_halt();
      logic [15:0] hpc, opc;
      int nreq = 0;
      bit got = 0;
      reset_dut(1);
      lat_lo = 2; lat_hi = 3;
      for (int i = 0; i < 20 && !m_out; i++) begin drive(1, 1, 0, '0, 0); advance(); end
      hpc = m_fpc; opc = m_rpc;
      drive(1, 1, 0, '0, 1);
      advance();
      for (int i = 0; i < 20; i++) begin
         drive(1'($urandom), 1, 0, '0, 0);
         ntot++;
         if ({imem_req, imem_addr, pc_out, instr_valid, halted} !== exp_ctl())
            $display("FAIL halt_ctl: got %h want %h", {imem_req, imem_addr, pc_out, instr_valid, halted}, exp_ctl());
         else npass++;
         if (imem_req !== 1'b0) nreq++;
         if (instr_valid === 1'b1 && instr_pc === opc && instr === memf(opc)) got = 1;
         advance();
      end
      ntot++;
      if (nreq != 0 || halted !== 1'b1 || pc_out !== hpc)
         $display("FAIL halt_stop: got req=%0d halted=%b pc=%h want 0 1 %h", nreq, halted, pc_out, hpc);
      else npass++;
      ntot++;
      if (!got) $display("FAIL halt_deliver: got none want pc %h delivered", opc);
      else npass++;
   endtask

   task automatic test_reset_mid();
      logic [15:0] seen[$];
      bit found = 0;
      reset_dut(1);
      lat_lo = 3; lat_hi = 3;
      for (int i = 0; i < 60 && !found; i++) begin
         drive(1, 0, 0, '0, 0); advance();
         found = (m_q.size() == 3) && m_out;
      end
      ntot++;
      if (!found) $display("FAIL rmid_setup: got no 3-entry state want one");
      else npass++;
      rst = 1'b1;
      drive(1, 1, 0, '0, 0);
      model_reset();
      ntot++;
      if ({imem_req, instr_valid, halted, pc_out} !== {3'b000, RST_PC})
         $display("FAIL rmid_now: got %h want %h", {imem_req, instr_valid, halted, pc_out}, {3'b000, RST_PC});
      else npass++;
      advance();
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         drive(i >= 4, 1, 0, '0, 0);
         ntot++;
         if ({imem_req, imem_addr, pc_out, instr_valid, halted} !== exp_ctl())
            $display("FAIL rmid_ctl: got %h want %h", {imem_req, imem_addr, pc_out, instr_valid, halted}, exp_ctl());
         else npass++;
         if (instr_valid === 1'b1) seen.push_back(instr_pc);
         advance();
      end
      ntot++;
      if (seen.size() == 0 || seen[0] !== RST_PC)
         $display("FAIL rmid_restart: got %0d pops first %h want %h",
                  seen.size(), (seen.size() != 0) ? seen[0] : 16'hxxxx, RST_PC);
      else npass++;
   endtask

   task automatic test_random();
      reset_dut(2);
      lat_lo = 1; lat_hi = 3;
      for (int i = 0; i < 400; i++) begin
         drive(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 16) == 0,
               (($urandom % 4) == 0) ? 16'hFFFA : 16'($urandom), 0);
         ntot++;
         if ({imem_req, imem_addr, pc_out, instr_valid, halted} !== exp_ctl())
            $display("FAIL rand_ctl: got %h want %h", {imem_req, imem_addr, pc_out, instr_valid, halted}, exp_ctl());
         else npass++;
         if (m_q.size() != 0) begin
            ntot++;
            if ({instr_pc, instr} !== exp_head())
               $display("FAIL rand_head: got %h want %h", {instr_pc, instr}, exp_head());
            else npass++;
         end
         advance();
      end
   endtask

   initial begin
      imem_rdy = 0; imem_rvalid = 0; imem_rdata = '0; instr_ready = 0;
      redirect_valid = 0; redirect_pc = '0; hlt = 0;
      model_reset();
      @(negedge clk);
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_wrap();
      test_halt();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, PC and memory address width.
REQ-002 SHALL have parameter DATA_W, default 16, instruction width.
REQ-003 SHALL have parameter DEPTH, default 4, prefetch queue entries (power of two, >= 2).
REQ-004 SHALL have parameter INC, default 2, PC step per instruction.
REQ-005 SHALL have parameter RESET_PC, default 0, fetch address after reset.
REQ-006 SHALL have ports, one per line:
 - clk  in  1  sole clock, rising edge.
 - rst  in  1  asynchronous, active-high reset.
 - imem_req  out  1  fetch request valid.
 - imem_addr  out  ADDR_W  fetch address.
 - imem_rdy  in  1  memory accepts request this cycle.
 - imem_rvalid  in  1  response data valid.
 - imem_rdata  in  DATA_W  response instruction.
 - instr_valid  out  1  queue head valid.
 - instr  out  DATA_W  queue head instruction.
 - instr_pc  out  ADDR_W  address of queue head.
 - instr_ready  in  1  consumer takes head this cycle.
 - redirect_valid  in  1  branch/jump redirect.
 - redirect_pc  in  ADDR_W  redirect target.
 - hlt  in  1  halt request.
 - halted  out  1  fetch permanently stopped.
 - pc_out  out  ADDR_W  current fetch PC.
REQ-007 Clock is clk; reset is rst, asynchronous and active-high.

Function
REQ-008 SHALL keep fetch PC, queue (DEPTH x {pc, instr}), count, outstanding bit, drop bit, halted bit as state.
REQ-009 imem_req SHALL be 1 iff !halted && !redirect_valid && !outstanding && (count < DEPTH); imem_addr SHALL equal fetch PC.
REQ-010 Request accepted when imem_req && imem_rdy: outstanding set, fetch PC += INC modulo 2^ADDR_W (wrap to 0, no flag).
REQ-011 At most one request outstanding; imem_rvalid earliest one cycle after acceptance; responses in order.
REQ-012 imem_rvalid with outstanding && !drop && !redirect_valid SHALL push {request pc, imem_rdata} to queue tail; outstanding cleared.
REQ-013 imem_rvalid with drop set or with redirect_valid high SHALL be discarded; outstanding and drop cleared.
REQ-014 Queue head visible on instr_valid/instr/instr_pc; instr_valid = (count != 0); pop when instr_valid && instr_ready.
REQ-015 Push and pop in same cycle: count unchanged; pop from empty SHALL not occur (instr_valid gates it).
REQ-016 Credit rule (count + outstanding <= DEPTH) SHALL guarantee no push into a full queue; overflow impossible.
REQ-017 Response-to-head latency: push at edge T, instr_valid high at T+1 when queue empty; no combinational bypass.
REQ-018 redirect_valid SHALL, at the next edge: empty queue (count 0, instr_valid 0), load fetch PC = redirect_pc, set drop if outstanding and no response in that cycle; pop ignored that cycle.
REQ-019 Redirect wins over simultaneous push, pop and acceptance (acceptance cannot occur: REQ-009).
REQ-020 hlt high at an edge SHALL set halted; halted sticky until rst; hlt and redirect same cycle: both take effect.
REQ-021 While halted: no new requests, fetch PC frozen, outstanding response still pushed per REQ-012, queue drains normally; redirect still flushes and loads PC.
REQ-022 pc_out SHALL equal fetch PC.
REQ-023 Unknown states SHALL not exist; all state bits explicitly reset.

Reset
REQ-024 rst high SHALL immediately set: fetch PC = RESET_PC, count 0, outstanding 0, drop 0, halted 0; outputs imem_req 0 while rst high, instr_valid 0, halted 0, pc_out RESET_PC.
REQ-025 Reset mid-transfer SHALL discard queue and any in-flight response; imem_rvalid arriving after deassertion with outstanding 0 SHALL be ignored.
REQ-026 First request (imem_addr = RESET_PC) SHALL be presented in the first cycle after rst deasserts.

Verification
REQ-027 Reset, imem_rdy=1, 1-cycle response, instr_ready=1 -> instr_pc sequence 0x0000, 0x0002, 0x0004, one instr every 2 cycles, data matches memory.
REQ-028 instr_ready=0, DEPTH=4 -> exactly 4 pushes, imem_req drops to 0, count 4; instr_ready=1 for one cycle -> one new request issued.
REQ-029 Request 0x0006 outstanding, redirect_valid with redirect_pc=0x0040 -> queue empties, late response discarded, next instr_pc = 0x0040.
REQ-030 Fetch PC 0xFFFE accepted -> pc_out wraps to 0x0000, next instr_pc 0x0000.
REQ-031 hlt pulse with request outstanding -> halted=1, that response still delivered, no further imem_req, pc_out frozen until rst.
REQ-032 rst asserted while queue holds 3 entries -> instr_valid 0 at once, pc_out RESET_PC, fetch restarts at RESET_PC after release.
